// File: rtl/dp_pkg.sv
// Shared widths, configuration record and helpers for the DisplayPort line timer.
package dp_pkg;

  localparam int DP_W      = 16;
  localparam int DP_F      = 15;
  localparam int DP_INC_W  = 17;
  localparam int DP_LEAD_W = 4;
  localparam int DP_FRST   = 7;
  localparam int DP_ACC_W  = DP_W + DP_F + 1;

  typedef struct packed {
    logic [DP_W-1:0]      htot;
    logic [DP_W-1:0]      vtot;
    logic [DP_W-1:0]      vact;
    logic [DP_INC_W-1:0]  sclkinc;
    logic [DP_LEAD_W-1:0] dmalead;
  } dp_cfg_t;

  // fiforeset down-counter is never narrower than 3 bits
  function automatic int cnt_width(input int frst);
    return ($clog2(frst + 1) > 3) ? $clog2(frst + 1) : 3;
  endfunction

endpackage

// File: rtl/dp_frac_acc.sv
// Fractional pixel accumulator: advances by inc per link clock and flags a wrap
// each time the integer pixel position reaches htot (a line is htot+1 pixels).
module dp_frac_acc
  import dp_pkg::*;
#(
  parameter int W     = DP_W,
  parameter int F     = DP_F,
  parameter int INC_W = DP_INC_W
) (
  input  logic             dpclk,
  input  logic             resetn,
  input  logic             clear,
  input  logic [W-1:0]     htot,
  input  logic [INC_W-1:0] inc,
  output logic             wrap
);

  localparam int AW = W + F + 1;
  localparam logic [AW-1:0] ONE = {{W{1'b0}}, 1'b1, {F{1'b0}}};

  // acc holds pixel position plus 1.0, so the fraction left over after a wrap
  // (which may dip below zero when inc < 1) is always representable unsigned.
  logic [AW-1:0] acc;
  logic [AW-1:0] acc_nxt;
  logic [W:0]    span;
  logic          hit;
  logic          run;

  assign span    = {1'b0, htot} + {{W{1'b0}}, 1'b1};
  assign hit     = acc[AW-1:F] >= span;
  assign run     = !clear && (inc != '0);
  assign wrap    = run && hit;
  assign acc_nxt = (hit ? acc - {span, {F{1'b0}}} : acc) + {{(AW-INC_W){1'b0}}, inc};

  // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge dpclk or negedge resetn) begin
    if (!resetn)    acc <= ONE;
    else if (clear) acc <= ONE;
    else if (run)   acc <= acc_nxt;
  end

endmodule

// File: rtl/dp_line_timer.sv
// Line/frame timing generator: line counter, frame-synchronous config shadowing,
// DMA kick with programmable lead and the FIFO-reset window that follows it.
module dp_line_timer
  import dp_pkg::*;
#(
  parameter int W      = DP_W,
  parameter int F      = DP_F,
  parameter int INC_W  = DP_INC_W,
  parameter int LEAD_W = DP_LEAD_W,
  parameter int FRST   = DP_FRST
) (
  input  logic              dpclk,
  input  logic              resetn,
  input  logic              enable,
  input  logic [W-1:0]      htot,
  input  logic [W-1:0]      vtot,
  input  logic [W-1:0]      vact,
  input  logic [INC_W-1:0]  sclkinc,
  input  logic [LEAD_W-1:0] dmalead,
  input  logic              cfgload,
  output logic              hstart,
  output logic              vstart,
  output logic              dmastart,
  output logic              fiforeset,
  output logic              vactive,
  output logic [W-1:0]      line,
  output logic              cfgbusy
);

  localparam int CW = cnt_width(FRST);
  localparam logic [CW-1:0] FRST_LD = CW'(FRST);

  dp_cfg_t       cfg_in;
  dp_cfg_t       pend;
  dp_cfg_t       shad;
  logic          wrap;
  logic          last_line;
  logic          frame_wrap;
  logic          dma_hit;
  logic          apply;
  logic [W-1:0]  lead_ext;
  logic [W-1:0]  line_nxt;
  logic [W-1:0]  vact_nxt;
  logic [CW-1:0] frst_cnt;

  assign cfg_in = '{htot: htot, vtot: vtot, vact: vact, sclkinc: sclkinc, dmalead: dmalead};

  dp_frac_acc #(.W(W), .F(F), .INC_W(INC_W)) u_acc (
    .dpclk  (dpclk),
    .resetn (resetn),
    .clear  (!enable),
    .htot   (shad.htot),
    .inc    (shad.sclkinc),
    .wrap   (wrap)
  );

  assign last_line  = line == shad.vtot;
  assign frame_wrap = wrap && last_line;
  assign lead_ext   = {{(W-LEAD_W){1'b0}}, shad.dmalead};
  // a lead larger than the frame would alias under modular subtraction, so it is masked
  assign dma_hit    = wrap && (lead_ext <= shad.vtot) && (line == shad.vtot - lead_ext);
  assign apply      = !enable || frame_wrap;
  assign line_nxt   = last_line ? '0 : line + {{(W-1){1'b0}}, 1'b1};
  assign vact_nxt   = apply ? pend.vact : shad.vact;
  assign fiforeset  = frst_cnt != '0;

  always_ff @(posedge dpclk or negedge resetn) begin
    if (!resetn) begin
      pend     <= '0;
      shad     <= '0;
      cfgbusy  <= 1'b0;
      hstart   <= 1'b0;
      vstart   <= 1'b0;
      dmastart <= 1'b0;
      vactive  <= 1'b0;
      line     <= '0;
      frst_cnt <= '0;
    end else begin
      // an apply always takes the old pending set; a simultaneous capture stays pending
      if (cfgload) pend <= cfg_in;
      if (apply)   shad <= pend;
      if (cfgload)    cfgbusy <= 1'b1;
      else if (apply) cfgbusy <= 1'b0;

      if (!enable) begin
        hstart   <= 1'b0;
        vstart   <= 1'b0;
        dmastart <= 1'b0;
        vactive  <= 1'b0;
        line     <= '0;
        frst_cnt <= '0;
      end else begin
        hstart   <= wrap;
        vstart   <= frame_wrap;
        dmastart <= dma_hit;
        if (wrap) line <= line_nxt;
        vactive  <= ((wrap ? line_nxt : line) < vact_nxt);
        if (dmastart)      frst_cnt <= FRST_LD;
        else if (fiforeset) frst_cnt <= frst_cnt - {{(CW-1){1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: tb/tb_dp_line_timer.sv
// Self-checking bench for dp_line_timer: per-cycle comparison against a pixel-position
// model plus directed timing measurements and randomized config/enable/reset traffic.
module tb_dp_line_timer;

  localparam int W      = 16;
  localparam int F      = 15;
  localparam int INC_W  = 17;
  localparam int LEAD_W = 4;
  localparam int FRST   = 7;
  localparam int ONE    = 1 << F;
  localparam longint NONE = -1000000;

  logic              dpclk = 1'b0;
  logic              resetn = 1'b0;
  logic              enable = 1'b0;
  logic              cfgload = 1'b0;
  logic [W-1:0]      htot = '0;
  logic [W-1:0]      vtot = '0;
  logic [W-1:0]      vact = '0;
  logic [INC_W-1:0]  sclkinc = '0;
  logic [LEAD_W-1:0] dmalead = '0;
  logic              hstart, vstart, dmastart, fiforeset, vactive, cfgbusy;
  logic [W-1:0]      line;

  dp_line_timer dut (
    .dpclk     (dpclk),
    .resetn    (resetn),
    .enable    (enable),
    .htot      (htot),
    .vtot      (vtot),
    .vact      (vact),
    .sclkinc   (sclkinc),
    .dmalead   (dmalead),
    .cfgload   (cfgload),
    .hstart    (hstart),
    .vstart    (vstart),
    .dmastart  (dmastart),
    .fiforeset (fiforeset),
    .vactive   (vactive),
    .line      (line),
    .cfgbusy   (cfgbusy)
  );

  always #5 dpclk = ~dpclk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: pixel position in 2^-F units, lines modulo vtot+1, config sets.
  typedef struct {
    int htot;
    int vtot;
    int vact;
    int inc;
    int lead;
  } mcfg_t;

  mcfg_t  pend, shad;
  bit     busy, eh, ev, ed, eva, efr;
  longint pos, cyc, last_dma;
  int     mline;

  longint hq[$], vq[$], dq[$], fq[$];
  int     dline[$], hline[$];
  bit     bq[$];

  function automatic void model_reset();
    pend = '{0, 0, 0, 0, 0};
    shad = '{0, 0, 0, 0, 0};
    busy = 0; eh = 0; ev = 0; ed = 0; eva = 0; efr = 0;
    pos = 0; mline = 0; last_dma = NONE;
  endfunction

  function automatic bit mwill_frame();
    return enable && shad.inc != 0 && pos >= longint'(shad.htot) * ONE && mline == shad.vtot;
  endfunction

  function automatic void model_edge();
    mcfg_t inp;
    bit    w, apply;
    inp = '{int'(htot), int'(vtot), int'(vact), int'(sclkinc), int'(dmalead)};
    cyc++;
    if (!enable) begin
      eh = 0; ev = 0; ed = 0; efr = 0;
      mline = 0; pos = 0; last_dma = NONE;
      apply = 1;
    end else begin
      w   = shad.inc != 0 && pos >= longint'(shad.htot) * ONE;
      eh  = w;
      ev  = w && mline == shad.vtot;
      ed  = w && shad.lead <= shad.vtot && mline == shad.vtot - shad.lead;
      efr = (cyc - last_dma >= 1) && (cyc - last_dma <= FRST);
      if (shad.inc != 0) pos = pos + shad.inc - (w ? longint'(shad.htot + 1) * ONE : 0);
      if (w) mline = (mline == shad.vtot) ? 0 : mline + 1;
      if (ed) last_dma = cyc;
      apply = ev;
    end
    if (apply) shad = pend;
    if (cfgload) begin
      pend = inp;
      busy = 1;
    end else if (apply) begin
      busy = 0;
    end
    eva = enable && (mline < shad.vact);
  endfunction

  task automatic compare_all();
    check("hstart", hstart, eh);
    check("vstart", vstart, ev);
    check("dmastart", dmastart, ed);
    check("fiforeset", fiforeset, efr);
    check("vactive", vactive, eva);
    check("line", line, mline);
    check("cfgbusy", cfgbusy, busy);
  endtask

  task automatic step();
    @(posedge dpclk);
    model_edge();
    @(negedge dpclk);
    compare_all();
    if (hstart) begin hq.push_back(cyc); hline.push_back(int'(line)); end
    if (vstart) begin vq.push_back(cyc); bq.push_back(cfgbusy); end
    if (dmastart) begin dq.push_back(cyc); dline.push_back(int'(line)); end
    if (fiforeset) fq.push_back(cyc);
  endtask

  task automatic clear_q();
    hq.delete(); vq.delete(); dq.delete(); fq.delete();
    dline.delete(); hline.delete(); bq.delete();
  endtask

  task automatic setcfg(input int h, input int v, input int va, input int inc, input int lead);
    htot = W'(h); vtot = W'(v); vact = W'(va); sclkinc = INC_W'(inc); dmalead = LEAD_W'(lead);
    cfgload = 1'b1;
    step();
    cfgload = 1'b0;
  endtask

  task automatic do_reset();
    #2 resetn = 1'b0;
    #1 model_reset();
    compare_all();
    @(negedge dpclk);
    resetn = 1'b1;
  endtask

  function automatic longint next_after(input longint q[$], input longint t);
    foreach (q[i]) if (q[i] > t) return q[i];
    return NONE;
  endfunction

  function automatic int count_in(input longint q[$], input longint lo, input longint hi);
    int n = 0;
    foreach (q[i]) if (q[i] >= lo && q[i] < hi) n++;
    return n;
  endfunction

  task automatic rand_inputs();
    htot    = W'($urandom_range(0, 6));
    vtot    = W'($urandom_range(0, 4));
    vact    = W'($urandom_range(0, 5));
    sclkinc = ($urandom_range(0, 9) == 0) ? '0 : INC_W'($urandom_range(ONE / 4, 2 * ONE));
    dmalead = LEAD_W'($urandom_range(0, 6));
  endtask

  initial begin
    bit found;
    longint vs_cyc;
    cyc = 0;
    model_reset();
    #1 compare_all();
    @(negedge dpclk);
    resetn = 1'b1;

    // 1: htot=4, inc=1.0, vtot=2
    setcfg(4, 2, 2, ONE, 0);
    step();
    enable = 1'b1;
    clear_q();
    repeat (62) step();
    for (int i = 1; i < 6; i++) check("t1_hgap", hq[i] - hq[i-1], 5);
    for (int i = 1; i < 3; i++) check("t1_vgap", vq[i] - vq[i-1], 15);
    for (int i = 0; i < 6; i++) check("t1_line_seq", hline[i], (i + 1) % 3);

    // 2: htot=3, inc=0.75 -> 16 lines per 85 cycles
    enable = 1'b0;
    setcfg(3, 2, 1, 24576, 0);
    step();
    enable = 1'b1;
    clear_q();
    repeat (130) step();
    check("t2_h_per_85", count_in(hq, hq[0], hq[0] + 85), 16);

    // 3: vtot=9, dmalead=2 -> dma leaving line 7, then an out-of-range lead
    enable = 1'b0;
    setcfg(2, 9, 5, ONE, 2);
    step();
    enable = 1'b1;
    clear_q();
    repeat (95) step();
    check("t3_dma_count", dq.size(), 3);
    foreach (dline[i]) check("t3_dma_line", dline[i], 8);
    check("t3_frst_len", count_in(fq, dq[0], dq[0] + 20), FRST);
    check("t3_frst_start", count_in(fq, dq[0] + 1, dq[0] + 2), 1);
    enable = 1'b0;
    setcfg(2, 9, 5, ONE, 12);
    step();
    enable = 1'b1;
    clear_q();
    repeat (100) step();
    check("t3_lead12_none", dq.size(), 0);

    // 4: htot 4 -> 8 mid-frame
    enable = 1'b0;
    setcfg(4, 2, 2, ONE, 0);
    step();
    enable = 1'b1;
    repeat (22) step();
    clear_q();
    setcfg(8, 2, 2, ONE, 0);
    check("t4_busy_set", cfgbusy, 1);
    repeat (60) step();
    foreach (hq[i]) if (i > 0 && hq[i] <= vq[0]) check("t4_old_gap", hq[i] - hq[i-1], 5);
    check("t4_new_gap", next_after(hq, vq[0]) - vq[0], 9);
    check("t4_busy_clr", bq[0], 0);

    // 5: cfgload coinciding with vstart
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mwill_frame()) found = 1;
      step();
    end
    check("t5_sync1", found, 1);
    setcfg(5, 2, 2, ONE, 0);
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      if (mwill_frame()) found = 1;
      else step();
    end
    check("t5_sync2", found, 1);
    clear_q();
    setcfg(6, 2, 2, ONE, 0);
    vs_cyc = cyc;
    check("t5_vstart", vstart, 1);
    check("t5_busy_kept", cfgbusy, 1);
    clear_q();
    repeat (60) step();
    check("t5_gap_a", hq[0] - vs_cyc, 6);
    check("t5_busy_clr", bq[0], 0);
    check("t5_gap_b", next_after(hq, vq[0]) - vq[0], 7);

    // 6: reset mid-line, restart, enable drop
    repeat (3) step();
    do_reset();
    enable = 1'b0;
    setcfg(3, 3, 2, ONE, 1);
    step();
    enable = 1'b1;
    clear_q();
    repeat (60) step();
    check("t6_first_vstart", vq[0], hq[3]);
    enable = 1'b0;
    step();
    check("t6_dis_line", line, 0);
    check("t6_dis_frst", fiforeset, 0);
    enable = 1'b1;
    repeat (20) step();

    // randomized traffic
    for (int s = 0; s < 6; s++) begin
      enable = 1'b0;
      rand_inputs();
      cfgload = 1'b1;
      step();
      cfgload = 1'b0;
      step();
      enable = 1'b1;
      for (int i = 0; i < 120; i++) begin
        rand_inputs();
        cfgload = ($urandom_range(0, 19) == 0);
        enable  = ($urandom_range(0, 49) != 0);
        step();
        if ($urandom_range(0, 199) == 0) do_reset();
      end
      cfgload = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
